// File: rtl/ep0_pkg.sv
// Shared constants and types for the EP0 standard-request engine.
// Request codes, descriptor types, FSM state encodings and the decoded-request record.
package ep0_pkg;

    localparam logic [7:0] REQ_GET_STATUS        = 8'h00;
    localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
    localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'h06;
    localparam logic [7:0] REQ_GET_CONFIGURATION = 8'h08;
    localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;

    localparam logic [7:0] BMRT_DEV_IN  = 8'h80;
    localparam logic [7:0] BMRT_IF_IN   = 8'h81;
    localparam logic [7:0] BMRT_EP_IN   = 8'h82;
    localparam logic [7:0] BMRT_DEV_OUT = 8'h00;

    localparam logic [7:0] DESC_DEVICE = 8'h01;
    localparam logic [7:0] DESC_CONFIG = 8'h02;
    localparam logic [7:0] DESC_STRING = 8'h03;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_LENRD    = 4'd2;
    localparam logic [3:0] ST_FETCH    = 4'd3;
    localparam logic [3:0] ST_PRESENT  = 4'd4;
    localparam logic [3:0] ST_PKT_WAIT = 4'd5;
    localparam logic [3:0] ST_ZLP      = 4'd6;
    localparam logic [3:0] ST_STATUS   = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;
    localparam logic [3:0] ST_STALL    = 4'd9;

    typedef enum logic [2:0] {
        KIND_ROM,
        KIND_STATUS,
        KIND_SET_ADDR,
        KIND_SET_CFG,
        KIND_STALL
    } req_kind_e;

    typedef struct packed {
        req_kind_e   kind;
        logic        stall;
        logic        need_lenrd;
        logic [15:0] fixed_len;
        logic [7:0]  stat_b0;
        logic [6:0]  new_addr;
        logic [7:0]  new_cfg;
    } req_dec_t;

endpackage

// File: rtl/ep0_req_decode.sv
// Registered SETUP decode: classifies the request and picks the ROM base / fixed length.
module ep0_req_decode
    import ep0_pkg::*;
#(
    parameter int ROM_AW       = 10,
    parameter int NUM_STRINGS  = 4,
    parameter int SELF_POWERED = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [7:0]                    bm_request_type,
    input  logic [7:0]                    b_request,
    input  logic [15:0]                   w_value,
    input  logic [ROM_AW-1:0]             desc_dev_offset,
    input  logic [ROM_AW-1:0]             desc_cfg_offset,
    input  logic [15:0]                   desc_cfg_len,
    input  logic [NUM_STRINGS*ROM_AW-1:0] desc_str_offset,
    input  logic [7:0]                    cfg_value,
    output req_dec_t                      dec,
    output logic [ROM_AW-1:0]             base
);

    req_dec_t          d;
    logic [ROM_AW-1:0] d_base;
    logic [ROM_AW-1:0] str_base;
    logic              str_ok;

    always_comb begin
        str_base = '0;
        str_ok   = 1'b0;
        for (int i = 0; i < NUM_STRINGS; i++) begin
            if (w_value[7:0] == 8'(i)) begin
                str_base = desc_str_offset[i*ROM_AW +: ROM_AW];
                str_ok   = 1'b1;
            end
        end

        d       = '0;
        d.kind  = KIND_STALL;
        d.stall = 1'b1;
        d_base  = '0;
        if (bm_request_type == BMRT_DEV_IN && b_request == REQ_GET_DESCRIPTOR) begin
            case (w_value[15:8])
                DESC_DEVICE: begin
                    d.kind = KIND_ROM; d.stall = 1'b0; d.need_lenrd = 1'b1;
                    d_base = desc_dev_offset;
                end
                DESC_CONFIG: begin
                    d.kind = KIND_ROM; d.stall = 1'b0; d.fixed_len = desc_cfg_len;
                    d_base = desc_cfg_offset;
                end
                DESC_STRING: begin
                    if (str_ok) begin
                        d.kind = KIND_ROM; d.stall = 1'b0; d.need_lenrd = 1'b1;
                        d_base = str_base;
                    end
                end
                default: ;
            endcase
        end else if (bm_request_type == BMRT_DEV_IN && b_request == REQ_GET_CONFIGURATION) begin
            d.kind = KIND_STATUS; d.stall = 1'b0; d.fixed_len = 16'd1;
            d.stat_b0 = cfg_value;
        end else if (b_request == REQ_GET_STATUS && (bm_request_type == BMRT_DEV_IN ||
                     bm_request_type == BMRT_IF_IN || bm_request_type == BMRT_EP_IN)) begin
            d.kind = KIND_STATUS; d.stall = 1'b0; d.fixed_len = 16'd2;
            d.stat_b0 = (bm_request_type == BMRT_DEV_IN && SELF_POWERED != 0) ? 8'h01 : 8'h00;
        end else if (bm_request_type == BMRT_DEV_OUT && b_request == REQ_SET_ADDRESS) begin
            d.kind = KIND_SET_ADDR; d.stall = 1'b0; d.new_addr = w_value[6:0];
        end else if (bm_request_type == BMRT_DEV_OUT && b_request == REQ_SET_CONFIGURATION &&
                     w_value[7:0] <= 8'd1) begin
            d.kind = KIND_SET_CFG; d.stall = 1'b0; d.new_cfg = w_value[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec  <= '0;
            base <= '0;
        end else if (load) begin
            dec  <= d;
            base <= d_base;
        end
    end

endmodule

// File: rtl/ep0_std_request_engine.sv
// EP0 standard-request engine: streams descriptor/status bytes in MAX_PKT packets with
// ZLP and checkpoint/rewind, and owns the device address and configuration.
module ep0_std_request_engine
    import ep0_pkg::*;
#(
    parameter int MAX_PKT      = 8,
    parameter int ROM_AW       = 10,
    parameter int NUM_STRINGS  = 4,
    parameter int SELF_POWERED = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear_request,
    input  logic                          req_valid,
    input  logic [7:0]                    bm_request_type,
    input  logic [7:0]                    b_request,
    input  logic [15:0]                   w_value,
    input  logic [15:0]                   w_index,
    input  logic [15:0]                   w_length,
    output logic [7:0]                    out_byte,
    output logic                          out_byte_valid,
    output logic                          out_byte_last,
    input  logic                          out_byte_ack,
    input  logic                          commit_write,
    input  logic                          reset_write,
    output logic [ROM_AW-1:0]             rom_addr,
    input  logic [7:0]                    rom_data,
    input  logic [ROM_AW-1:0]             desc_dev_offset,
    input  logic [ROM_AW-1:0]             desc_cfg_offset,
    input  logic [15:0]                   desc_cfg_len,
    input  logic [NUM_STRINGS*ROM_AW-1:0] desc_str_offset,
    output logic [6:0]                    dev_address,
    output logic                          dev_configured,
    output logic [7:0]                    cfg_value,
    output logic                          req_stall
);

    localparam int         PW       = $clog2(MAX_PKT);
    localparam logic [7:0] PKT_LAST = 8'(MAX_PKT - 1);

    req_dec_t          dec;
    logic [ROM_AW-1:0] dec_base;
    logic [3:0]        state;
    logic [15:0]       index, checkpoint, desc_len, xfer_len;
    logic [7:0]        pkt_cnt;
    logic [1:0]        phase;
    logic              at_end, last_byte, zlp_need;
    logic [3:0]        fetch_st, end_st;
    logic              unused_bits;

    // wIndex carries LANGID/recipient ids that this engine does not interpret
    assign unused_bits = ^w_index;

    ep0_req_decode #(
        .ROM_AW(ROM_AW), .NUM_STRINGS(NUM_STRINGS), .SELF_POWERED(SELF_POWERED)
    ) u_decode (
        .clk(clk), .reset(reset),
        .load(state == ST_IDLE && req_valid && !clear_request),
        .bm_request_type(bm_request_type), .b_request(b_request), .w_value(w_value),
        .desc_dev_offset(desc_dev_offset), .desc_cfg_offset(desc_cfg_offset),
        .desc_cfg_len(desc_cfg_len), .desc_str_offset(desc_str_offset),
        .cfg_value(cfg_value), .dec(dec), .base(dec_base)
    );

    assign xfer_len  = (desc_len < w_length) ? desc_len : w_length;
    assign at_end    = index >= xfer_len;
    assign last_byte = (pkt_cnt == PKT_LAST) || (index == xfer_len - 16'd1);
    assign zlp_need  = (xfer_len < w_length) && (xfer_len[PW-1:0] == '0);
    assign fetch_st  = (dec.kind == KIND_STATUS) ? ST_STATUS : ST_FETCH;
    assign end_st    = zlp_need ? ST_ZLP : ST_DONE;

    always_ff @(posedge clk) begin
        if (reset || clear_request || !req_valid) begin
            state          <= ST_IDLE;
            index          <= '0;
            checkpoint     <= '0;
            pkt_cnt        <= '0;
            desc_len       <= '0;
            phase          <= '0;
            out_byte       <= '0;
            out_byte_valid <= 1'b0;
            out_byte_last  <= 1'b0;
            rom_addr       <= '0;
            // a dropped req_valid aborts the transfer but a stall stays visible
            if (reset || clear_request) req_stall <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_DECODE;
                ST_DECODE: begin
                    index      <= '0;
                    checkpoint <= '0;
                    pkt_cnt    <= '0;
                    phase      <= '0;
                    desc_len   <= dec.fixed_len;
                    if (dec.stall) begin
                        req_stall <= 1'b1;
                        state     <= ST_STALL;
                    end else if (dec.kind == KIND_SET_ADDR || dec.kind == KIND_SET_CFG) begin
                        state <= ST_DONE;
                    end else if (dec.kind == KIND_STATUS) begin
                        state <= ST_STATUS;
                    end else if (dec.need_lenrd) begin
                        rom_addr <= dec_base;
                        state    <= ST_LENRD;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_LENRD: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd1) begin
                        desc_len <= {8'h00, rom_data};
                        phase    <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (phase == 2'd0 && at_end) begin
                        out_byte_last <= zlp_need;
                        state         <= end_st;
                    end else if (phase == 2'd0) begin
                        rom_addr <= dec_base + index[ROM_AW-1:0];
                        phase    <= 2'd1;
                    end else if (phase == 2'd1) begin
                        phase <= 2'd2;
                    end else begin
                        out_byte       <= rom_data;
                        out_byte_valid <= 1'b1;
                        out_byte_last  <= last_byte;
                        phase          <= '0;
                        state          <= ST_PRESENT;
                    end
                end
                ST_STATUS: begin
                    if (at_end) begin
                        out_byte_last <= zlp_need;
                        state         <= end_st;
                    end else begin
                        out_byte       <= (index == 16'd0) ? dec.stat_b0 : 8'h00;
                        out_byte_valid <= 1'b1;
                        out_byte_last  <= last_byte;
                        state          <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (reset_write) begin
                        out_byte_valid <= 1'b0;
                        out_byte_last  <= 1'b0;
                        index          <= checkpoint;
                        pkt_cnt        <= '0;
                        state          <= fetch_st;
                    end else if (out_byte_ack) begin
                        out_byte_valid <= 1'b0;
                        out_byte_last  <= 1'b0;
                        index          <= index + 16'd1;
                        pkt_cnt        <= pkt_cnt + 8'd1;
                        state          <= out_byte_last ? ST_PKT_WAIT : fetch_st;
                    end
                end
                ST_PKT_WAIT: begin
                    if (commit_write) begin
                        checkpoint <= index;
                        pkt_cnt    <= '0;
                        state      <= fetch_st;
                    end else if (reset_write) begin
                        index   <= checkpoint;
                        pkt_cnt <= '0;
                        state   <= fetch_st;
                    end
                end
                ST_ZLP: begin
                    if (out_byte_ack) begin
                        out_byte_last <= 1'b0;
                        state         <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address only moves after the status stage; configuration applies at decode
    always_ff @(posedge clk) begin
        if (reset) begin
            dev_address    <= '0;
            cfg_value      <= '0;
            dev_configured <= 1'b0;
        end else if (!clear_request && req_valid) begin
            if (state == ST_DECODE && !dec.stall && dec.kind == KIND_SET_CFG) begin
                cfg_value      <= dec.new_cfg;
                dev_configured <= |dec.new_cfg;
            end
            if (state == ST_DONE && commit_write && dec.kind == KIND_SET_ADDR)
                dev_address <= dec.new_addr;
        end
    end

endmodule
